// File: rtl/run_det_arb.sv
// Shared run-length detector: a round-robin arbiter picks one serial channel per
// cycle and a per-channel context decides whether the consumed bit extends a run.

module run_det_ctx #(
  parameter int RUN  = 4,
  parameter int CNTW = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic gnt_i,
  input  logic bit_i,
  input  logic clr_i,
  output logic hit_o
);
  logic            valid_q;
  logic            last_q;
  logic [CNTW-1:0] cnt_q;
  logic            restart;

  // A clear in the same cycle as a grant discards the old run before the bit lands.
  assign restart = !valid_q || (bit_i != last_q) || clr_i;
  assign hit_o   = gnt_i && !restart && (cnt_q >= CNTW'(RUN - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (gnt_i) begin
      valid_q <= 1'b1;
      last_q  <= bit_i;
      if (restart)
        cnt_q <= CNTW'(1);
      else if (cnt_q < CNTW'(RUN))
        cnt_q <= cnt_q + CNTW'(1);
    end else if (clr_i) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end
  end
endmodule

module run_det_arb #(
  parameter int NCH = 4,
  parameter int RUN = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NCH-1:0]           req_i,
  input  logic [NCH-1:0]           bit_in_i,
  input  logic [NCH-1:0]           clr_i,
  output logic [NCH-1:0]           gnt_o,
  output logic                     det_valid_o,
  output logic [$clog2(NCH)-1:0]   det_ch_o,
  output logic                     det_val_o
);
  localparam int CHW  = $clog2(NCH);
  localparam int CNTW = $clog2(RUN + 1);

  logic [CHW-1:0] ptr_q;
  logic [NCH-1:0] gnt_d;
  logic [CHW-1:0] gidx;
  logic           any_gnt;
  logic [NCH-1:0] hit;
  logic           det_valid_q;
  logic [CHW-1:0] det_ch_q;
  logic           det_val_q;

  // Priority search starting at ptr, wrapping NCH-1 -> 0.
  always_comb begin
    int c;
    gnt_d   = '0;
    gidx    = '0;
    any_gnt = 1'b0;
    c       = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(ptr_q) + i) % NCH;
      if (!any_gnt && req_i[c]) begin
        any_gnt  = 1'b1;
        gnt_d[c] = 1'b1;
        gidx     = CHW'(c);
      end
    end
  end

  assign gnt_o = rst_ni ? gnt_d : '0;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      run_det_ctx #(.RUN(RUN), .CNTW(CNTW)) u_ctx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .gnt_i  (gnt_o[g]),
        .bit_i  (bit_in_i[g]),
        .clr_i  (clr_i[g]),
        .hit_o  (hit[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_val_q   <= 1'b0;
    end else begin
      det_valid_q <= |hit;
      if (any_gnt)
        ptr_q <= (gidx == CHW'(NCH - 1)) ? '0 : gidx + CHW'(1);
      if (|hit) begin
        det_ch_q  <= gidx;
        det_val_q <= bit_in_i[gidx];
      end
    end
  end

  assign det_valid_o = det_valid_q;
  assign det_ch_o    = det_ch_q;
  assign det_val_o   = det_val_q;
endmodule
